barrel_shift_pipe: RTL and testbench

BARREL_SHIFT_PIPE -- requirements
Module: barrel_shift_pipe

---
 rtl/barrel_shift_pipe.sv | 177 +++++++++++++++++
 tb/tb_barrel_shift_pipe.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_pipe.sv
// Two-stage pipelined barrel shifter with ARM-style carry-out.
// S1 normalises the shift amount; S2 shifts, computes carry and holds the result under backpressure.
module barrel_shift_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       shift_type,
  input  logic [7:0]       shift_num,
  input  logic             reg_amt,
  input  logic             not_shift,
  input  logic [WIDTH-1:0] x,
  input  logic             carry_in,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             c,
  output logic [TAG_W-1:0] tag_out
);

  localparam int         LW     = $clog2(WIDTH);
  localparam logic [8:0] WIDTH9 = 9'(WIDTH);

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;

  logic             s1_valid;
  logic [1:0]       s1_type;
  logic [8:0]       s1_amt;
  logic             s1_bypass;
  logic             s1_rrx;
  logic [WIDTH-1:0] s1_x;
  logic             s1_cin;
  logic [TAG_W-1:0] s1_tag;

  logic             s2_adv;
  logic [8:0]       d_amt;
  logic             d_bypass;
  logic             d_rrx;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // Immediate #0 encodings are remapped here so S2 sees only plain amounts.
  always_comb begin
    d_amt    = {1'b0, shift_num};
    d_bypass = not_shift;
    d_rrx    = 1'b0;
    if (!reg_amt) begin
      d_amt = 9'(shift_num[LW-1:0]);
      if (shift_num[LW-1:0] == '0) begin
        case (shift_type)
          SH_LSL:         d_bypass = 1'b1;
          SH_LSR, SH_ASR: d_amt    = WIDTH9;
          default:        d_rrx    = 1'b1;
        endcase
      end
    end else if (shift_num == 8'd0) begin
      d_bypass = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_type   <= '0;
      s1_amt    <= '0;
      s1_bypass <= 1'b0;
      s1_rrx    <= 1'b0;
      s1_x      <= '0;
      s1_cin    <= 1'b0;
      s1_tag    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_type   <= shift_type;
        s1_amt    <= d_amt;
        s1_bypass <= d_bypass;
        s1_rrx    <= d_rrx;
        s1_x      <= x;
        s1_cin    <= carry_in;
        s1_tag    <= tag_in;
      end
    end
  end

  logic [LW-1:0]      nm1;
  logic [LW-1:0]      rot;
  logic [WIDTH-1:0]   lsl_pre;
  logic [WIDTH-1:0]   lsr_pre;
  logic [2*WIDTH-1:0] ror_wide;
  logic [WIDTH-1:0]   ror_y;
  logic [WIDTH-1:0]   sh_y;
  logic               sh_c;

  // Carry is the last bit shifted out, i.e. the edge bit after shifting by n-1.
  assign nm1      = LW'(s1_amt - 9'd1);
  assign rot      = s1_amt[LW-1:0];
  assign lsl_pre  = s1_x << nm1;
  assign lsr_pre  = s1_x >> nm1;
  assign ror_wide = {s1_x, s1_x} >> rot;
  assign ror_y    = ror_wide[WIDTH-1:0];

  always_comb begin
    sh_y = s1_x;
    sh_c = s1_cin;
    if (s1_bypass) begin
      sh_y = s1_x;
      sh_c = s1_cin;
    end else if (s1_rrx) begin
      sh_y = {s1_cin, s1_x[WIDTH-1:1]};
      sh_c = s1_x[0];
    end else begin
      case (s1_type)
        SH_LSL: begin
          if (s1_amt < WIDTH9) begin
            sh_y = s1_x << rot;
            sh_c = lsl_pre[WIDTH-1];
          end else if (s1_amt == WIDTH9) begin
            sh_y = '0;
            sh_c = s1_x[0];
          end else begin
            sh_y = '0;
            sh_c = 1'b0;
          end
        end
        SH_LSR: begin
          if (s1_amt < WIDTH9) begin
            sh_y = s1_x >> rot;
            sh_c = lsr_pre[0];
          end else if (s1_amt == WIDTH9) begin
            sh_y = '0;
            sh_c = s1_x[WIDTH-1];
          end else begin
            sh_y = '0;
            sh_c = 1'b0;
          end
        end
        SH_ASR: begin
          if (s1_amt < WIDTH9) begin
            sh_y = $signed(s1_x) >>> rot;
            sh_c = lsr_pre[0];
          end else begin
            sh_y = {WIDTH{s1_x[WIDTH-1]}};
            sh_c = s1_x[WIDTH-1];
          end
        end
        default: begin
          sh_y = ror_y;
          sh_c = ror_y[WIDTH-1];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      y         <= '0;
      c         <= 1'b0;
      tag_out   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        y       <= sh_y;
        c       <= sh_c;
        tag_out <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Bench for barrel_shift_pipe: directed corner cases, backpressure, random traffic and reset flush,
// all checked against a spec-level reference model and an in-order expectation queue.
module tb_barrel_shift_pipe;

  localparam int WIDTH = 32;
  localparam int TAG_W = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [1:0]        shift_type = '0;
  logic [7:0]        shift_num = '0;
  logic              reg_amt = 1'b0;
  logic              not_shift = 1'b0;
  logic [WIDTH-1:0]  x = '0;
  logic              carry_in = 1'b0;
  logic [TAG_W-1:0]  tag_in = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [WIDTH-1:0]  y;
  logic              c;
  logic [TAG_W-1:0]  tag_out;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] y;
    logic        c;
    logic [3:0]  tag;
  } exp_t;
  exp_t q[$];

  logic [31:0] prev_y = '0;
  logic        prev_c = 1'b0;
  logic [3:0]  prev_tag = '0;
  bit          prev_stall = 1'b0;

  always #5 clk = ~clk;

  barrel_shift_pipe #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .shift_type(shift_type), .shift_num(shift_num), .reg_amt(reg_amt), .not_shift(not_shift),
    .x(x), .carry_in(carry_in), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .c(c), .tag_out(tag_out)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Shift semantics written straight from the rules, using integer amounts.
  function automatic logic [32:0] ref_op(input logic [1:0] t, input logic [7:0] num,
                                         input logic ra, input logic ns,
                                         input logic [31:0] xv, input logic ci);
    int n;
    int r;
    logic [31:0] yv;
    logic        cv;
    n = ra ? int'(num) : (int'(num) % 32);
    if (ns) return {xv, ci};
    if (n == 0) begin
      if (ra || t == 2'd0) return {xv, ci};
      if (t == 2'd3) return {ci, xv[31:1], xv[0]};
      n = 32;
    end
    yv = '0;
    cv = 1'b0;
    case (t)
      2'd0: begin
        if (n < 32) begin yv = xv << n; cv = xv[32-n]; end
        else if (n == 32) begin yv = '0; cv = xv[0]; end
      end
      2'd1: begin
        if (n < 32) begin yv = xv >> n; cv = xv[n-1]; end
        else if (n == 32) begin yv = '0; cv = xv[31]; end
      end
      2'd2: begin
        if (n < 32) begin yv = $unsigned($signed(xv) >>> n); cv = xv[n-1]; end
        else begin yv = {32{xv[31]}}; cv = xv[31]; end
      end
      default: begin
        r = n % 32;
        if (r == 0) begin yv = xv; cv = xv[31]; end
        else begin yv = (xv >> r) | (xv << (32 - r)); cv = yv[31]; end
      end
    endcase
    return {yv, cv};
  endfunction

  // One clock cycle, starting and ending at a falling edge.
  task automatic cyc(input bit iv, input bit ordy, output bit acc, output bit ov);
    exp_t e;
    logic [32:0] r;
    in_valid  = iv;
    out_ready = ordy;
    #1;
    ov  = out_valid;
    acc = in_valid && in_ready;
    if (prev_stall) begin
      chk("hold_y", y, prev_y);
      chk("hold_c", c, prev_c);
      chk("hold_tag", tag_out, prev_tag);
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_out", out_valid, 0);
      else begin
        e = q.pop_front();
        chk("res_y", y, e.y);
        chk("res_c", c, e.c);
        chk("res_tag", tag_out, e.tag);
      end
    end
    if (acc) begin
      r = ref_op(shift_type, shift_num, reg_amt, not_shift, x, carry_in);
      e.y = r[32:1];
      e.c = r[0];
      e.tag = tag_in;
      q.push_back(e);
    end
    chk("occupancy_le2", q.size() <= 2, 1);
    prev_stall = out_valid && !out_ready;
    prev_y     = y;
    prev_c     = c;
    prev_tag   = tag_out;
    @(negedge clk);
  endtask

  task automatic dir(input string name, input logic [1:0] t, input logic [7:0] num, input logic ra,
                     input logic ns, input logic [31:0] xv, input logic ci,
                     input logic [31:0] ey, input logic ec);
    bit acc, ov;
    shift_type = t; shift_num = num; reg_amt = ra; not_shift = ns; x = xv; carry_in = ci;
    tag_in = 4'($urandom);
    cyc(1'b1, 1'b1, acc, ov);
    chk({name, "_acc"}, acc, 1);
    cyc(1'b0, 1'b1, acc, ov);
    chk({name, "_lat1"}, ov, 0);
    cyc(1'b0, 1'b1, acc, ov);
    chk({name, "_lat2"}, ov, 1);
    chk({name, "_y"}, prev_y, ey);
    chk({name, "_c"}, prev_c, ec);
  endtask

  task automatic rand_fields();
    shift_type = 2'($urandom);
    reg_amt    = 1'($urandom);
    not_shift  = ($urandom_range(0, 9) == 0);
    carry_in   = 1'($urandom);
    x          = $urandom;
    tag_in     = 4'($urandom);
    case ($urandom_range(0, 5))
      0: shift_num = 8'd0;
      1: shift_num = 8'd1;
      2: shift_num = 8'd31;
      3: shift_num = 8'd32;
      4: shift_num = 8'd33;
      default: shift_num = 8'($urandom);
    endcase
  endtask

  initial begin
    bit acc, ov;
    int issued;

    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk("rst_c", c, 0);
    chk("rst_tag", tag_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);

    dir("lsl_imm1",  2'd0, 8'd1,  1'b0, 1'b0, 32'h80000001, 1'b0, 32'h00000002, 1'b1);
    dir("lsr_imm0",  2'd1, 8'd0,  1'b0, 1'b0, 32'h80000000, 1'b0, 32'h00000000, 1'b1);
    dir("asr_reg40", 2'd2, 8'd40, 1'b1, 1'b0, 32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b1);
    dir("ror_reg32", 2'd3, 8'd32, 1'b1, 1'b0, 32'h80000001, 1'b0, 32'h80000001, 1'b1);
    dir("rrx",       2'd3, 8'd0,  1'b0, 1'b0, 32'h00000003, 1'b1, 32'h80000001, 1'b1);
    dir("lsl_reg33", 2'd0, 8'd33, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h00000000, 1'b0);
    dir("lsl_reg32", 2'd0, 8'd32, 1'b1, 1'b0, 32'h00000001, 1'b0, 32'h00000000, 1'b1);
    dir("lsr_reg33", 2'd1, 8'd33, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0);
    dir("ror_reg4",  2'd3, 8'd4,  1'b1, 1'b0, 32'h0000000F, 1'b0, 32'hF0000000, 1'b1);
    dir("not_shift", 2'd1, 8'd5,  1'b1, 1'b1, 32'h000000F0, 1'b0, 32'h000000F0, 1'b0);
    for (int t = 0; t < 4; t++)
      dir("reg0", 2'(t), 8'd0, 1'b1, 1'b0, 32'h12345678, 1'b1, 32'h12345678, 1'b1);

    // Eight back-to-back ops with out_ready cycling 1,0,0.
    issued = 0;
    rand_fields();
    tag_in = 4'(issued);
    for (int t = 0; t < 80 && (issued < 8 || q.size() > 0); t++) begin
      cyc(issued < 8, (t % 3) == 0, acc, ov);
      if (acc) begin
        issued++;
        rand_fields();
        tag_in = 4'(issued);
      end
    end
    chk("bp_issued", issued, 8);
    chk("bp_drained", q.size(), 0);

    for (int t = 0; t < 400; t++) begin
      rand_fields();
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, acc, ov);
    end
    for (int t = 0; t < 10 && q.size() > 0; t++) cyc(1'b0, 1'b1, acc, ov);
    chk("rand_drained", q.size(), 0);

    // Reset with two operations in flight.
    rand_fields();
    cyc(1'b1, 1'b0, acc, ov);
    chk("flush_acc1", acc, 1);
    rand_fields();
    cyc(1'b1, 1'b0, acc, ov);
    chk("flush_acc2", acc, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_y", y, 0);
    chk("flush_c", c, 0);
    chk("flush_tag", tag_out, 0);
    q.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 1);
    @(negedge clk);
    for (int t = 0; t < 5; t++) begin
      cyc(1'b0, 1'b1, acc, ov);
      chk("no_stale", ov, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
